// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: op codes, default width,
// packed status flag record and buffer occupancy states.
// Optional feature: define ALU_PARITY_EN to add a parity flag to every entry.
package alu_pkg;

   localparam int unsigned WIDTH_DEF = 4;

   localparam logic [2:0] OP_AND = 3'd0;
   localparam logic [2:0] OP_OR  = 3'd1;
   localparam logic [2:0] OP_XOR = 3'd2;
   localparam logic [2:0] OP_ADD = 3'd3;
   localparam logic [2:0] OP_SUB = 3'd4;

   typedef struct packed {
      logic z;
      logic c;
      logic n;
      logic err;
`ifdef ALU_PARITY_EN
      logic p;
`endif
   } flags_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } occ_e;

   // True for the op codes that have a defined function unit behind them.
   function automatic logic op_is_defined(input logic [2:0] op);
      return (op <= OP_SUB);
   endfunction

endpackage

// File: rtl/alu_result_stage_if.sv
// Handshake and data bundle around the ALU result stage.
// slave: the stage itself. master: upstream units plus downstream consumer.
// Optional feature: ALU_PARITY_EN adds flag_p.
interface alu_result_stage_if #(
   parameter int unsigned WIDTH = alu_pkg::WIDTH_DEF
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] and_res;
   logic [WIDTH-1:0] or_res;
   logic [WIDTH-1:0] xor_res;
   logic [WIDTH-1:0] sum_res;
   logic             cout;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             flag_z;
   logic             flag_c;
   logic             flag_n;
   logic             flag_err;
`ifdef ALU_PARITY_EN
   logic             flag_p;
`endif

   modport slave (
      input  in_valid, op, and_res, or_res, xor_res, sum_res, cout, out_ready,
      output in_ready, out_valid, result, flag_z, flag_c, flag_n, flag_err
`ifdef ALU_PARITY_EN
      , output flag_p
`endif
   );

   modport master (
      output in_valid, op, and_res, or_res, xor_res, sum_res, cout, out_ready,
      input  in_ready, out_valid, result, flag_z, flag_c, flag_n, flag_err
`ifdef ALU_PARITY_EN
      , input flag_p
`endif
   );

endinterface

// File: rtl/alu_result_fmt.sv
// Combinational result select and flag generation for one ALU operation.
// Optional feature: ALU_PARITY_EN also produces the parity flag.
module alu_result_fmt
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] and_res,
   input  logic [WIDTH-1:0] or_res,
   input  logic [WIDTH-1:0] xor_res,
   input  logic [WIDTH-1:0] sum_res,
   input  logic             cout,
   output logic [WIDTH-1:0] result,
   output flags_t           flags
);

   // Pick the unit output for op, then derive all flags from that value.
   always_comb begin
      result = '0;
      flags  = '0;
      case (op)
         OP_AND: result = and_res;
         OP_OR:  result = or_res;
         OP_XOR: result = xor_res;
         OP_ADD: begin
            result  = sum_res;
            flags.c = cout;
         end
         OP_SUB: begin
            // Upstream computes a + ~b + 1, so a missing carry means a borrow.
            result  = sum_res;
            flags.c = ~cout;
         end
         default: result = '0;
      endcase
      flags.err = ~op_is_defined(op);
      flags.z   = (result == '0);
      flags.n   = result[WIDTH-1];
`ifdef ALU_PARITY_EN
      flags.p   = ^result;
`endif
   end

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage of the 4-bit ALU: selects the result, stores it
// with its flags in a main register plus one skid register, and hands it
// downstream over valid/ready. in_ready is registered and independent of
// out_ready.
// Optional feature: ALU_PARITY_EN adds the stored parity flag flag_p.
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input logic               clk,
   input logic               rst_n,
   alu_result_stage_if.slave bus
);

   logic [WIDTH-1:0] new_res;
   flags_t           new_flags;

   logic [WIDTH-1:0] main_res;
   flags_t           main_flags;
   logic [WIDTH-1:0] skid_res;
   flags_t           skid_flags;

   occ_e             state;
   logic             in_ready_r;
   logic             out_valid_r;
   logic             acc;
   logic             pop;

   alu_result_fmt #(
      .WIDTH (WIDTH)
   ) u_fmt (
      .op      (bus.op),
      .and_res (bus.and_res),
      .or_res  (bus.or_res),
      .xor_res (bus.xor_res),
      .sum_res (bus.sum_res),
      .cout    (bus.cout),
      .result  (new_res),
      .flags   (new_flags)
   );

   // Handshake events for this cycle.
   always_comb begin
      acc = bus.in_valid && in_ready_r;
      pop = out_valid_r && bus.out_ready;
   end

   // Occupancy FSM with registered in_ready/out_valid. The head of the
   // queue always lives in main; skid only holds the second entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_EMPTY;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         main_res    <= '0;
         main_flags  <= '0;
         skid_res    <= '0;
         skid_flags  <= '0;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (acc) begin
                  main_res    <= new_res;
                  main_flags  <= new_flags;
                  state       <= ST_ONE;
                  out_valid_r <= 1'b1;
               end
            end
            ST_ONE: begin
               if (acc && !pop) begin
                  skid_res   <= new_res;
                  skid_flags <= new_flags;
                  state      <= ST_TWO;
                  in_ready_r <= 1'b0;
               end else if (acc && pop) begin
                  main_res   <= new_res;
                  main_flags <= new_flags;
               end else if (pop) begin
                  state       <= ST_EMPTY;
                  out_valid_r <= 1'b0;
               end
            end
            ST_TWO: begin
               if (pop) begin
                  main_res   <= skid_res;
                  main_flags <= skid_flags;
                  state      <= ST_ONE;
                  in_ready_r <= 1'b1;
               end
            end
            default: begin
               state       <= ST_EMPTY;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.result    = main_res;
   assign bus.flag_z    = main_flags.z;
   assign bus.flag_c    = main_flags.c;
   assign bus.flag_n    = main_flags.n;
   assign bus.flag_err  = main_flags.err;
`ifdef ALU_PARITY_EN
   assign bus.flag_p    = main_flags.p;
`endif

endmodule
